data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/mem_resp_ram.sv | 33 +++
 rtl/data_mem_responder.sv | 119 +++++++++++
 tb/tb_data_mem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the wait-state data memory responder.
// The FSM encoding, default sizing and the legal-address check are defined here.
package mem_resp_pkg;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_DEPTH_LOG2  = 8;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_e;

  // A byte address is bad if it is not word aligned or lies beyond the array.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr,
                                    input int unsigned depth_log2);
    logic [ADDR_W-1:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // rdata only moves on a read, so it holds steady for the whole response.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_W/8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: accepts one request, inserts WAIT_CYCLES wait
// states, performs the access, then holds the response until it is taken.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  // Request: transfer on an edge where req_valid && req_ready.
  // Response: transfer on an edge where resp_valid && resp_ready; the
  // response payload is stable while resp_valid is high.
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output mem_resp_state_e     state
);

  mem_resp_state_e     state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q;
  logic                err_q;
  logic                rsel_q;
  logic                access;
  logic                accept;
  logic                addr_err;

  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [DATA_W-1:0]   ram_rdata;

  assign accept   = (state_q == IDLE) && req_valid && ready_q;
  assign addr_err = addr_bad(addr_q, DEPTH_LOG2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is registered so it stays low until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      if (access) begin
        err_q  <= addr_err;
        rsel_q <= !addr_err && !wr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  mem_resp_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (access && !addr_err),
    .we    (wr_q),
    .addr  (addr_q[DEPTH_LOG2+1:2]),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign req_ready  = ready_q;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rsel_q ? ram_rdata : '0;
  assign resp_err   = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table of stores/loads on a
// WAIT_CYCLES=2 instance plus hand sequences for stall, reset and throughput.
module tb_data_mem_responder;
  import mem_resp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0]     req_addr, req_wdata, resp_rdata;
  logic [3:0]      req_be;
  mem_resp_state_e state0;

  logic            req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1;
  logic [31:0]     req_addr1, req_wdata1, resp_rdata1;
  logic [3:0]      req_be1;
  mem_resp_state_e state1;

  data_mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .state(state0)
  );

  data_mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_fast (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1), .state(state1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t        vecs[15];
  vec_t        vecs1[4];
  logic [32:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance, entered at a negedge.
  task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, output logic [31:0] rd,
                            output logic er, output int lat);
    int g;
    g = 0; rd = '0; er = 1'b0; lat = -1;
    while (!req_ready && g < 40) begin @(negedge clk); g++; end
    chk("req_ready_wait", req_ready, 1'b1);
    if (!req_ready) return;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk);
    @(negedge clk);
    chk("req_ready_busy", req_ready, 1'b0);
    // Junk request held during the wait: must be ignored entirely.
    req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    lat = 0;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    req_valid = 1'b0;
    chk("resp_valid_wait", resp_valid, 1'b1);
    if (!resp_valid) return;
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_clear", resp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, g, acc_cyc, idx, nresp;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,       32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b0, 32'h12,       32'h0,        4'hF, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h400,      32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h12,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 32'h80000010, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDE22BE44, 1'b0};
    vecs[9]  = '{1'b1, 32'h3FC,      32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h3FC,      32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    vecs[11] = '{1'b1, 32'h10,       32'h00000000, 4'h0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDE22BE44, 1'b0};
    vecs[13] = '{1'b1, 32'h20,       32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h20,       32'h0,        4'hF, 32'h12345678, 1'b0};

    vecs1[0] = '{1'b1, 32'h40, 32'h0BADF00D, 4'hF, 32'h0,        1'b0};
    vecs1[1] = '{1'b0, 32'h40, 32'h0,        4'hF, 32'h0BADF00D, 1'b0};
    vecs1[2] = '{1'b0, 32'h41, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs1[3] = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0BADF00D, 1'b0};

    // Clock/reset
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0;
    resp_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_state", state0, IDLE);
    reset = 1'b1;
    #1;
    chk("ready_before_edge", req_ready, 1'b0);
    @(negedge clk);
    chk("ready_first_edge", req_ready, 1'b1);

    // resp_ready while idle does nothing
    resp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_resp_ready_rv", resp_valid, 1'b0);
      chk("idle_resp_ready_st", state0, IDLE);
    end
    resp_ready = 1'b0;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      run_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].be, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("v%0d_err", i), er, vecs[i].er);
      chk($sformatf("v%0d_latency", i), lat, 3);
    end

    // Response stall: hold resp_ready low for 5 cycles
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (!resp_valid && g < 40) begin @(negedge clk); g++; end
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
      chk("stall_rv", resp_valid, 1'b1);
      chk("stall_rdata", resp_rdata, 32'hDE22BE44);
      chk("stall_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_state", state0, IDLE);
    chk("stall_release_rv", resp_valid, 1'b0);
    @(negedge clk);
    resp_ready = 1'b0;
    run_access(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    chk("stall_after_rdata", rd, 32'hDE22BE44);

    // Reset one cycle after accepting a store: store must be dropped
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("wait_rst_state", state0, IDLE);
    chk("wait_rst_ready", req_ready, 1'b0);
    chk("wait_rst_rv", resp_valid, 1'b0);
    chk("wait_rst_rdata", resp_rdata, 32'h0);
    chk("wait_rst_err", resp_err, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_access(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    chk("wait_rst_mem", rd, 32'h12345678);
    chk("wait_rst_mem_err", er, 1'b0);

    // Reset during RESP: response dropped, no replay
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3FC; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (!resp_valid && g < 40) begin @(negedge clk); g++; end
    chk("resp_rst_pre_rdata", resp_rdata, 32'hA5A5A5A5);
    #2;
    reset = 1'b0;
    #1;
    chk("resp_rst_rv", resp_valid, 1'b0);
    chk("resp_rst_rdata", resp_rdata, 32'h0);
    chk("resp_rst_state", state0, IDLE);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("resp_rst_no_replay", resp_valid, 1'b0);
    end
    chk("resp_rst_ready", req_ready, 1'b1);

    // WAIT_CYCLES=0 instance: back-to-back with resp_ready held high
    acc_cyc = -100; idx = 0; nresp = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (resp_valid1) begin
        chk("fast_resp_latency", cyc - acc_cyc, 2);
        if (exp_q.size() > 0) chk("fast_resp_data", {resp_err1, resp_rdata1}, exp_q.pop_front());
        else chk("fast_resp_unexpected", resp_valid1, 1'b0);
        nresp++;
      end
      if (req_ready1 && idx < 4) begin
        if (idx > 0) chk("fast_accept_spacing", cyc - acc_cyc, 3);
        acc_cyc = cyc;
        req_valid1 = 1'b1; req_write1 = vecs1[idx].w; req_addr1 = vecs1[idx].a;
        req_wdata1 = vecs1[idx].d; req_be1 = vecs1[idx].be;
        exp_q.push_back({vecs1[idx].er, vecs1[idx].rd});
        idx++;
      end else if (req_ready1) begin
        req_valid1 = 1'b0;
      end
    end
    chk("fast_resp_count", nresp, 4);
    chk("fast_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
